// File: rtl/tour_cmd_player.sv
// tour_cmd_player: replays a stored list of 16-bit commands into RemoteComm, advancing on each ACK.
// Optional build macro TOUR_PLAYER_RETRY_EN: resend an entry once after its first response timeout.
module tour_cmd_player #(
  parameter int         DEPTH      = 32,
  parameter int         TMO_CYCLES = 4_000_000,
  parameter logic [7:0] ACK        = 8'hA5,
  localparam int        FW         = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [15:0]   load_data,
  input  logic          clear,
  input  logic          start,
  input  logic          abort,
  output logic [15:0]   cmd,
  output logic          send_cmd,
  input  logic          cmd_sent,
  input  logic          resp_rdy,
  input  logic [7:0]    resp,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [FW-1:0] fill,
  output logic [FW-1:0] idx
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TMO_CYCLES+1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES-1);
  localparam logic [TW-1:0] TMO_MAX  = '1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_SENT, WAIT_RESP, DONE, ERR} state_t;
  state_t state, state_nx;

  logic [15:0]   mem [DEPTH];
  logic [TW-1:0] tmo_cnt;
  logic [FW-1:0] idx_inc;
  logic          idle_st, busy_st, start_go, load_go, abort_go;
  logic          ack_hit, nak_hit, tmo_hit, tmo_fail, retry_go;

  assign idle_st  = (state == IDLE) || (state == DONE) || (state == ERR);
  assign busy_st  = (state == ISSUE) || (state == WAIT_SENT) || (state == WAIT_RESP);
  assign start_go = idle_st && start && !clear;
  assign load_go  = idle_st && load && !start && !clear && (fill < FW'(DEPTH));
  assign abort_go = busy_st && abort && !clear;
  assign idx_inc  = idx + FW'(1);
  assign ack_hit  = (state == WAIT_RESP) && resp_rdy && (resp == ACK);
  assign nak_hit  = (state == WAIT_RESP) && resp_rdy && (resp != ACK);
  assign tmo_hit  = (state == WAIT_RESP) && !resp_rdy && (tmo_cnt == TMO_LAST);
  assign tmo_fail = tmo_hit && !retry_go;

`ifdef TOUR_PLAYER_RETRY_EN
  logic retried;
  assign retry_go = tmo_hit && !retried;

  // one resend per entry; re-armed whenever idx moves or a run restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           retried <= 1'b0;
    else if (clear || start_go || ack_hit) retried <= 1'b0;
    else if (retry_go && !abort)           retried <= 1'b1;
  end
`else
  assign retry_go = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nx = (fill == '0) ? DONE : ISSUE;
      ISSUE:           state_nx = WAIT_SENT;
      WAIT_SENT:       if (cmd_sent) state_nx = WAIT_RESP;
      WAIT_RESP: begin
        if (ack_hit)      state_nx = (idx_inc == fill) ? DONE : ISSUE;
        else if (nak_hit) state_nx = ERR;
        else if (tmo_hit) state_nx = retry_go ? ISSUE : ERR;
      end
      default:         state_nx = IDLE;
    endcase
    if (abort && busy_st) state_nx = ERR;
    if (clear)            state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // buffer has no reset; contents survive runs so start replays the list
  always_ff @(posedge clk) begin
    if (load_go) mem[fill[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= '0;
      send_cmd <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      fill     <= '0;
      idx      <= '0;
      tmo_cnt  <= '0;
    end else begin
      send_cmd <= (state_nx == ISSUE);
      busy     <= (state_nx == ISSUE) || (state_nx == WAIT_SENT) || (state_nx == WAIT_RESP);
      if (state == WAIT_SENT && cmd_sent)                 tmo_cnt <= '0;
      else if (state == WAIT_RESP && tmo_cnt != TMO_MAX)  tmo_cnt <= tmo_cnt + TW'(1);

      if (clear) begin
        cmd      <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
        err_code <= 2'b00;
        fill     <= '0;
        idx      <= '0;
      end else if (start_go) begin
        idx      <= '0;
        done     <= (fill == '0);
        err      <= 1'b0;
        err_code <= 2'b00;
        if (fill != '0) cmd <= mem[0];
      end else if (load_go) begin
        fill <= fill + FW'(1);
      end else if (abort_go) begin
        err      <= 1'b1;
        err_code <= 2'b11;
      end else if (ack_hit) begin
        idx <= idx_inc;
        if (idx_inc == fill) done <= 1'b1;
        else                 cmd  <= mem[idx_inc[AW-1:0]];
      end else if (nak_hit) begin
        err      <= 1'b1;
        err_code <= 2'b01;
      end else if (tmo_fail) begin
        err      <= 1'b1;
        err_code <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_tour_cmd_player.sv
// Bench for tour_cmd_player: directed steps plus randomized tours checked against a queue model.
module tb_tour_cmd_player;
  localparam int DEPTH = 4;
  localparam int TMO   = 1000;
  localparam int FW    = $clog2(DEPTH+1);
  localparam logic [7:0] ACK = 8'hA5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic load = 1'b0, clear = 1'b0, start = 1'b0, abort = 1'b0;
  logic cmd_sent = 1'b0, resp_rdy = 1'b0;
  logic [15:0] load_data = '0;
  logic [7:0]  resp = '0;
  logic [15:0] cmd;
  logic send_cmd, busy, done, err;
  logic [1:0] err_code;
  logic [FW-1:0] fill, idx;

  int n_cmp = 0, n_fail = 0;
  logic [15:0] model_q[$];
  logic [15:0] sent_q[$];

  always #5 clk = ~clk;

  tour_cmd_player #(.DEPTH(DEPTH), .TMO_CYCLES(TMO), .ACK(ACK)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_data(load_data), .clear(clear),
    .start(start), .abort(abort), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .fill(fill), .idx(idx));

  always @(negedge clk) if (rst_n && send_cmd) sent_q.push_back(cmd);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d);
    load = 1'b1; load_data = d; tick(); load = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(d);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    model_q.delete(); sent_q.delete();
  endtask

  task automatic serve_one(input logic [7:0] r, input int dly);
    int t = 0;
    while (!send_cmd && t < 60) begin tick(); t++; end
    chk("send_seen", 32'(send_cmd), 32'd1);
    if (!send_cmd) return;
    tick();
    repeat ($urandom_range(0, 3)) tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    repeat (dly - 1) tick();
    resp = r; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0; resp = 8'($urandom);
  endtask

  // play the stored list, answering entry i with rs[i]; expectations come from the first non-ACK
  task automatic run_plan(input logic [7:0] rs[$], input int dmin, input int dmax, input string tag);
    int n = model_q.size();
    int k = n;
    bit nakd;
    sent_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    chk({tag, "_start_lat"}, 32'(send_cmd), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      serve_one(rs[i], $urandom_range(dmin, dmax));
      if (rs[i] != ACK) begin k = i; break; end
    end
    nakd = (k < n);
    chk({tag, "_done_next"}, 32'(done), nakd ? 32'd0 : 32'd1);
    chk({tag, "_err_next"},  32'(err),  nakd ? 32'd1 : 32'd0);
    repeat (10) tick();
    chk({tag, "_sent_cnt"}, 32'(sent_q.size()), nakd ? 32'(k + 1) : 32'(n));
    for (int i = 0; i < sent_q.size() && i < n; i++)
      chk({tag, "_sent_val"}, 32'(sent_q[i]), 32'(model_q[i]));
    chk({tag, "_idx"},      32'(idx),      32'(k));
    chk({tag, "_err_code"}, 32'(err_code), nakd ? 32'd1 : 32'd0);
    chk({tag, "_busy_end"}, 32'(busy),     32'd0);
  endtask

  initial begin
    logic [7:0] rs[$];
    int n, t, exp_sends;
    logic [7:0] r;

    // reset state
    #12;
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_send", 32'(send_cmd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    rst_n = 1'b1;
    tick();

    // basic tour, 100-cycle responder
    do_load(16'h2000); do_load(16'h4BF1); do_load(16'h57F2);
    chk("basic_fill", 32'(fill), 32'd3);
    rs = '{ACK, ACK, ACK};
    run_plan(rs, 100, 100, "basic");

    // replay from DONE, NAK on the second entry
    rs = '{ACK, 8'h5A, ACK};
    run_plan(rs, 100, 100, "nak");

    // randomized tours
    for (int it = 0; it < 6; it++) begin
      do_clear();
      rs.delete();
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) begin
        do_load(16'($urandom));
        r = 8'($urandom);
        if (r == ACK) r = ~ACK;
        rs.push_back(($urandom_range(0, 3) == 0) ? r : ACK);
      end
      chk("rand_fill", 32'(fill), 32'(n));
      run_plan(rs, 1, 30, "rand");
    end

    // full buffer: extra loads are dropped
    do_clear();
    for (int j = 0; j < DEPTH + 2; j++) do_load(16'($urandom));
    chk("full_fill", 32'(fill), 32'(DEPTH));
    rs.delete();
    for (int j = 0; j < DEPTH; j++) rs.push_back(ACK);
    run_plan(rs, 1, 5, "full");

    // timeout
    do_clear();
    do_load(16'h2000); do_load(16'h1234);
    start = 1'b1; tick(); start = 1'b0; tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    t = 0;
    while (!err && !send_cmd && t < 2500) begin tick(); t++; end
    chk("tmo_lat", 32'(t), 32'(TMO));
`ifdef TOUR_PLAYER_RETRY_EN
    chk("retry_send", 32'(send_cmd), 32'd1);
    chk("retry_cmd", 32'(cmd), 32'h2000);
    chk("retry_noerr", 32'(err), 32'd0);
    tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    t = 0;
    while (!err && !send_cmd && t < 2500) begin tick(); t++; end
    chk("tmo2_lat", 32'(t), 32'(TMO));
    exp_sends = 2;
`else
    exp_sends = 1;
`endif
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_code", 32'(err_code), 32'd2);
    chk("tmo_idx", 32'(idx), 32'd0);
    repeat (5) tick();
    chk("tmo_sends", 32'(sent_q.size()), 32'(exp_sends));
    if (sent_q.size() > 0) chk("tmo_last_cmd", 32'(sent_q[sent_q.size()-1]), 32'h2000);

    // empty start, then start+load together
    do_clear();
    chk("clr_fill", 32'(fill), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd0);
    start = 1'b1; load = 1'b1; load_data = 16'hDEAD; tick(); start = 1'b0; load = 1'b0;
    chk("startload_fill", 32'(fill), 32'd0);
    chk("startload_done", 32'(done), 32'd1);
    repeat (5) tick();
    chk("empty_sends", 32'(sent_q.size()), 32'd0);

    // abort: ignored when idle, then during WAIT_RESP with a late ACK
    do_clear();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle", 32'(err), 32'd0);
    do_load(16'h1111); do_load(16'h2222);
    start = 1'b1; tick(); start = 1'b0; tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    repeat (5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_err", 32'(err), 32'd1);
    chk("abort_code", 32'(err_code), 32'd3);
    chk("abort_busy", 32'(busy), 32'd0);
    resp = ACK; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
    repeat (3) tick();
    chk("late_idx", 32'(idx), 32'd0);
    chk("late_code", 32'(err_code), 32'd3);
    chk("late_done", 32'(done), 32'd0);

    // clear beats abort/start/load mid-run
    sent_q.delete();
    start = 1'b1; tick(); start = 1'b0; tick();
    clear = 1'b1; abort = 1'b1; start = 1'b1; load = 1'b1; tick();
    clear = 1'b0; abort = 1'b0; start = 1'b0; load = 1'b0;
    model_q.delete();
    chk("clrpri_busy", 32'(busy), 32'd0);
    chk("clrpri_fill", 32'(fill), 32'd0);
    chk("clrpri_err", 32'(err), 32'd0);
    chk("clrpri_code", 32'(err_code), 32'd0);

    // async reset during WAIT_SENT
    do_load(16'h7E57);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd", 32'(cmd), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_fill", 32'(fill), 32'd0);
    chk("arst_send", 32'(send_cmd), 32'd0);
    #1 rst_n = 1'b1;
    model_q.delete();
    tick();

    // replay from DONE after reload
    start = 1'b1; tick(); start = 1'b0;
    chk("replay_pre_done", 32'(done), 32'd1);
    do_load(16'hBEEF);
    rs = '{ACK};
    run_plan(rs, 3, 8, "replay");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
